// File: rtl/fw_interface_arb_if.sv
// Bus bundle between the firmware-interface arbiter, its two Wishbone masters
// and the shared slave; the master modport is the arbiter's own view.
interface fw_interface_arb_if;
   logic [63:0] m_adr_i;
   logic [63:0] m_dat_i;
   logic [7:0]  m_sel_i;
   logic [1:0]  m_we_i;
   logic [1:0]  m_cyc_i;
   logic [1:0]  m_stb_i;
   logic [1:0]  m_ack_o;
   logic [1:0]  m_err_o;
   logic [1:0]  m_rty_o;
   logic [63:0] m_dat_o;
   logic [31:0] s_adr_o;
   logic [31:0] s_dat_o;
   logic [3:0]  s_sel_o;
   logic        s_we_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_ack_i;
   logic        s_err_i;
   logic        s_rty_i;
   logic [31:0] s_dat_i;

   modport master (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      input  s_ack_i, s_err_i, s_rty_i, s_dat_i,
      output m_ack_o, m_err_o, m_rty_o, m_dat_o,
      output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
   );

   modport slave (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_cyc_i, m_stb_i,
      output s_ack_i, s_err_i, s_rty_i, s_dat_i,
      input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
      input  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o
   );
endinterface

// File: rtl/fw_interface_arb.sv
// Two-master round-robin Wishbone arbiter for the firmware test interface slave,
// with a stall watchdog that aborts hung bus cycles.
module fw_interface_arb #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int TO_WIDTH       = 16
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   fw_interface_arb_if.master        bus,
   output logic [1:0]                grant_o,
   output logic                      timeout_o
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_ABORT = 2'd2;
   localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

   logic [1:0]          state_reg, state_next;
   logic                gnt_reg, gnt_next;
   logic                last_reg, last_next;
   logic [TO_WIDTH-1:0] wd_reg, wd_next, wd_inc;
   logic                timeout_reg, timeout_next;
   logic                g_cyc, g_stb, s_resp, in_grant, in_abort;
   logic [1:0]          gnt_oh, ack_v, err_v, rty_v;
   logic [63:0]         dat_v;

   assign g_cyc    = bus.m_cyc_i[gnt_reg];
   assign g_stb    = bus.m_stb_i[gnt_reg];
   assign s_resp   = bus.s_ack_i | bus.s_err_i | bus.s_rty_i;
   assign in_grant = (state_reg == ST_GRANT);
   assign in_abort = (state_reg == ST_ABORT);
   assign wd_inc   = wd_reg + 1'b1;

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      last_next    = last_reg;
      wd_next      = '0;
      timeout_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Contention goes to whoever did not own the previous cycle.
            if (|bus.m_cyc_i) begin
               state_next = ST_GRANT;
               gnt_next   = (&bus.m_cyc_i) ? ~last_reg : bus.m_cyc_i[1];
            end
         end
         ST_GRANT: begin
            if (!g_cyc) begin
               state_next = ST_IDLE;
               last_next  = gnt_reg;
            end else if (TIMEOUT_CYCLES != 0 && g_stb && !s_resp) begin
               wd_next = wd_inc;
               if (wd_inc == TO_LIMIT) begin
                  state_next   = ST_ABORT;
                  timeout_next = 1'b1;
               end
            end
         end
         ST_ABORT: begin
            if (!g_cyc) begin
               state_next = ST_IDLE;
               last_next  = gnt_reg;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg   <= ST_IDLE;
         gnt_reg     <= 1'b0;
         last_reg    <= 1'b1;
         wd_reg      <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         last_reg    <= last_next;
         wd_reg      <= wd_next;
         timeout_reg <= timeout_next;
      end
   end

   assign gnt_oh    = (state_reg == ST_IDLE) ? 2'b00 : (gnt_reg ? 2'b10 : 2'b01);
   assign grant_o   = gnt_oh;
   assign timeout_o = timeout_reg;

   // Request path: combinational from the owner, forced quiet outside GRANT.
   assign bus.s_adr_o = in_grant ? (gnt_reg ? bus.m_adr_i[63:32] : bus.m_adr_i[31:0]) : 32'd0;
   assign bus.s_dat_o = in_grant ? (gnt_reg ? bus.m_dat_i[63:32] : bus.m_dat_i[31:0]) : 32'd0;
   assign bus.s_sel_o = in_grant ? (gnt_reg ? bus.m_sel_i[7:4] : bus.m_sel_i[3:0]) : 4'd0;
   assign bus.s_we_o  = in_grant & bus.m_we_i[gnt_reg];
   assign bus.s_cyc_o = in_grant & g_cyc;
   assign bus.s_stb_o = in_grant & g_cyc & g_stb;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_resp
         assign ack_v[gi] = in_grant & gnt_oh[gi] & bus.s_ack_i;
         assign rty_v[gi] = in_grant & gnt_oh[gi] & bus.s_rty_i;
         // The abort error is the one-cycle timeout pulse, not a slave response.
         assign err_v[gi] = gnt_oh[gi] & ((in_grant & bus.s_err_i) | (in_abort & timeout_reg));
         assign dat_v[32*gi +: 32] = (in_grant && gnt_oh[gi]) ? bus.s_dat_i : 32'd0;
      end
   endgenerate

   assign bus.m_ack_o = ack_v;
   assign bus.m_err_o = err_v;
   assign bus.m_rty_o = rty_v;
   assign bus.m_dat_o = dat_v;
endmodule

// File: tb/tb_fw_interface_arb.sv
// Directed bench for fw_interface_arb: one instance with an 8-cycle watchdog,
// one with the watchdog disabled.
module tb_fw_interface_arb;
   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i = 1'b1;
   logic [1:0] grant_o, grant0;
   logic       timeout_o, timeout0;
   int         errors = 0;
   int         checks = 0;

   fw_interface_arb_if bus();
   fw_interface_arb_if bus0();

   fw_interface_arb #(.TIMEOUT_CYCLES(8), .TO_WIDTH(16)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .bus      (bus),
      .grant_o  (grant_o),
      .timeout_o(timeout_o)
   );

   fw_interface_arb #(.TIMEOUT_CYCLES(0), .TO_WIDTH(16)) dut0 (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .bus      (bus0),
      .grant_o  (grant0),
      .timeout_o(timeout0)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   task automatic go();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic smp();
      @(negedge wb_clk_i);
   endtask

   task automatic clear_inputs();
      bus.m_adr_i = '0; bus.m_dat_i = '0; bus.m_sel_i = '0; bus.m_we_i = '0;
      bus.m_cyc_i = '0; bus.m_stb_i = '0;
      bus.s_ack_i = 1'b0; bus.s_err_i = 1'b0; bus.s_rty_i = 1'b0; bus.s_dat_i = '0;
      bus0.m_adr_i = '0; bus0.m_dat_i = '0; bus0.m_sel_i = '0; bus0.m_we_i = '0;
      bus0.m_cyc_i = '0; bus0.m_stb_i = '0;
      bus0.s_ack_i = 1'b0; bus0.s_err_i = 1'b0; bus0.s_rty_i = 1'b0; bus0.s_dat_i = '0;
   endtask

   task automatic apply_reset();
      go();
      wb_rst_i = 1'b1;
      clear_inputs();
      go();
      go();
      wb_rst_i = 1'b0;
   endtask

   initial begin
      int seen;
      clear_inputs();

      // Reset dominates an active request.
      go(); go();
      bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
      go(); smp();
      check("rst_grant", grant_o, 2'b00);
      check("rst_scyc", bus.s_cyc_o, 1'b0);
      check("rst_timeout", timeout_o, 1'b0);
      check("rst_mdat", bus.m_dat_o, 64'd0);

      // m0 write alone.
      apply_reset();
      go();
      bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01; bus.m_we_i = 2'b01;
      bus.m_adr_i = 64'h0000_0000_0000_0004; bus.m_dat_i = 64'h0000_0000_DEAD_BEEF;
      bus.m_sel_i = 8'h0F;
      smp(); check("wr_lat_grant", grant_o, 2'b00);
      go(); smp();
      check("wr_grant", grant_o, 2'b01);
      check("wr_sadr", bus.s_adr_o, 32'h4);
      check("wr_sdat", bus.s_dat_o, 32'hDEADBEEF);
      check("wr_ssel_we", {bus.s_sel_o, bus.s_we_o, bus.s_cyc_o, bus.s_stb_o}, 7'b1111_111);
      check("wr_noack", bus.m_ack_o, 2'b00);
      go(); bus.s_ack_i = 1'b1; smp();
      check("wr_ack", bus.m_ack_o, 2'b01);
      go(); bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; smp();
      check("wr_hold_grant", grant_o, 2'b01);
      go(); smp();
      check("wr_idle_grant", grant_o, 2'b00);

      // Simultaneous requests: m0 first, then m1 read.
      apply_reset();
      go();
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11; bus.m_we_i = 2'b01;
      bus.m_adr_i = {32'h14, 32'h8}; bus.m_sel_i = 8'hFF;
      go(); smp();
      check("sim_grant1", grant_o, 2'b01);
      check("sim_sadr0", bus.s_adr_o, 32'h8);
      go(); bus.s_ack_i = 1'b1; smp();
      check("sim_ack0", bus.m_ack_o, 2'b01);
      go(); bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10; smp();
      check("sim_grant3", grant_o, 2'b01);
      go(); smp();
      check("sim_grant4", grant_o, 2'b00);
      go(); bus.s_ack_i = 1'b1; bus.s_dat_i = 32'h12345678; smp();
      check("sim_grant5", grant_o, 2'b10);
      check("sim_sadr1", bus.s_adr_o, 32'h14);
      check("sim_swe1", bus.s_we_o, 1'b0);
      check("sim_ack1", bus.m_ack_o, 2'b10);
      check("sim_mdat1", bus.m_dat_o, 64'h12345678_00000000);
      go(); bus.s_ack_i = 1'b0; bus.s_dat_i = '0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
      go(); smp();
      check("sim_idle", grant_o, 2'b00);

      // Fairness with both masters re-requesting immediately.
      apply_reset();
      go();
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11; bus.m_we_i = 2'b00;
      for (int k = 0; k < 6; k++) begin
         go(); bus.s_ack_i = 1'b1; smp();
         check($sformatf("fair_grant%0d", k), grant_o, (k % 2) ? 2'b10 : 2'b01);
         check($sformatf("fair_ack%0d", k), bus.m_ack_o, (k % 2) ? 2'b10 : 2'b01);
         go(); bus.s_ack_i = 1'b0; bus.m_cyc_i[k % 2] = 1'b0; bus.m_stb_i[k % 2] = 1'b0;
         go(); bus.m_cyc_i[k % 2] = 1'b1; bus.m_stb_i[k % 2] = 1'b1; smp();
         check($sformatf("fair_gap%0d", k), grant_o, 2'b00);
      end

      // Watchdog abort on a silent slave, m1 waiting.
      apply_reset();
      go();
      bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11;
      for (int c = 1; c <= 8; c++) begin
         go(); smp();
         check($sformatf("wd_stall%0d", c), {bus.m_err_o, timeout_o, bus.s_cyc_o}, 4'b0001);
      end
      go(); smp();
      check("wd_abort_err", bus.m_err_o, 2'b01);
      check("wd_abort_to", timeout_o, 1'b1);
      check("wd_abort_scyc", {bus.s_cyc_o, bus.s_stb_o}, 2'b00);
      go(); smp();
      check("wd_pulse_end", {bus.m_err_o, timeout_o, bus.s_cyc_o}, 4'b0000);
      go(); bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10;
      go(); smp();
      check("wd_idle", grant_o, 2'b00);
      go(); bus.s_ack_i = 1'b1; bus.s_dat_i = 32'hCAFEF00D; smp();
      check("wd_m1_grant", grant_o, 2'b10);
      check("wd_m1_resp", {bus.m_ack_o, bus.m_err_o}, 4'b1000);
      check("wd_m1_dat", bus.m_dat_o, 64'hCAFEF00D_00000000);
      go(); bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;

      // Ack on the limit cycle beats the abort.
      apply_reset();
      go();
      bus.m_cyc_i = 2'b01; bus.m_stb_i = 2'b01;
      for (int c = 1; c <= 7; c++) go();
      go(); bus.s_ack_i = 1'b1; smp();
      check("bnd_ack", {bus.m_ack_o, bus.m_err_o, timeout_o}, 5'b01_00_0);
      go(); bus.s_ack_i = 1'b0; bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00; smp();
      check("bnd_noabort", {grant_o, bus.m_err_o, timeout_o}, 5'b01_00_0);
      go(); smp();
      check("bnd_idle", grant_o, 2'b00);

      // Disabled watchdog: long stall never errors.
      apply_reset();
      go();
      bus0.m_cyc_i = 2'b01; bus0.m_stb_i = 2'b01;
      seen = 0;
      for (int i = 0; i < 1000; i++) begin
         go(); smp();
         if (bus0.m_err_o != 2'b00 || timeout0) seen++;
      end
      check("nowd_errs", seen, 0);
      check("nowd_grant", grant0, 2'b01);
      check("nowd_stb", bus0.s_stb_o, 1'b1);
      go(); bus0.s_ack_i = 1'b1; smp();
      check("nowd_ack", bus0.m_ack_o, 2'b01);
      go(); bus0.s_ack_i = 1'b0; bus0.m_cyc_i = 2'b00; bus0.m_stb_i = 2'b00;

      // Reset mid-cycle while m1 owns the bus.
      apply_reset();
      go();
      bus.m_cyc_i = 2'b10; bus.m_stb_i = 2'b10; bus.m_adr_i = {32'h20, 32'h0};
      go(); bus.m_cyc_i = 2'b11; bus.m_stb_i = 2'b11; smp();
      check("rmid_grant", grant_o, 2'b10);
      check("rmid_stb", bus.s_stb_o, 1'b1);
      go(); wb_rst_i = 1'b1;
      go(); wb_rst_i = 1'b0; bus.s_ack_i = 1'b1; smp();
      check("rmid_reset_grant", grant_o, 2'b00);
      check("rmid_reset_scyc", bus.s_cyc_o, 1'b0);
      check("rmid_late_ack", bus.m_ack_o, 2'b00);
      go(); bus.s_ack_i = 1'b0; smp();
      check("rmid_m0_first", grant_o, 2'b01);
      go(); bus.m_cyc_i = 2'b00; bus.m_stb_i = 2'b00;
      go();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
